fifo_read_agent: RTL and testbench
==================================

# fifo_read_agent

Reader-side agent for the delayed-output FIFO. It issues `read_en` pulses to the FIFO whenever words are available and local space is guaranteed, tracks reads in flight across the FIFO's fixed output-pipeline latency, and captures each returned word into a small local buffer. Captured words are presented downstream on a valid/ready stream. It sits between the FIFO's read port and any consumer that can apply backpressure, so the consumer never has to know the FIFO's read latency.

## Interface
Parameters:
- `DATA_WIDTH`, 4: FIFO word width.
- `READ_LATENCY`, 4: rising edges from the edge that samples `fifo_read_en`=1 to the edge at which the returned word is valid on `fifo_data`. Must be ≥1.
- `SKID_DEPTH`, 8: local buffer entries. Must be ≥ `READ_LATENCY`+1 and a power of two.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: permits new FIFO reads.
- `fifo_empty` in 1: FIFO empty flag; registered, and updates the cycle after a read.
- `fifo_read_en` out 1: read strobe to the FIFO.
- `fifo_data` in `DATA_WIDTH`: FIFO read data.
- `m_valid` out 1: downstream word available.
- `m_ready` in 1: downstream accepts.
- `m_data` out `DATA_WIDTH`: downstream word (head of buffer).
- `busy` out 1: high when state ≠ IDLE.
- `rd_count` out 8: count of words delivered downstream; wraps from 255 to 0.

## Operation
- Outstanding = `inflight` + `buf_count`.
  - `inflight` is the number of reads issued but not yet captured; at most `READ_LATENCY`.
  - `buf_count` is 0..`SKID_DEPTH`.
- `fifo_read_en` is combinational: `enable` & !`fifo_empty` & (outstanding < `SKID_DEPTH`) & !`rst` held.
  - One word is read per edge at which it is sampled high.
- In-flight tracking: a `READ_LATENCY`-bit tag shift register shifts in `fifo_read_en` every edge.
  - When the tag exits, `fifo_data` is written at the buffer write pointer on that same edge.
- Buffer: circular, `log2(SKID_DEPTH)`-bit read and write pointers, natural wrap.
  - `m_valid` = (`buf_count` ≠ 0); `m_data` = entry at the read pointer.
  - A pop occurs on an edge with `m_valid`&`m_ready`; the read pointer advances and `rd_count` increments.
- A capture and a pop on the same edge: both pointers advance and `buf_count` is unchanged. This is legal even when `buf_count` = `SKID_DEPTH`, because credit accounting prevents a capture into a full buffer with no pop.
- The buffer can never overflow. This is an invariant, and the bench asserts it.
- State machine:
  - IDLE → RUN when `enable`=1.
  - RUN → DRAIN when `enable`=0 and outstanding > 0.
  - RUN → IDLE when `enable`=0 and outstanding = 0.
  - DRAIN → RUN when `enable`=1.
  - DRAIN → IDLE when outstanding = 0 and `enable`=0.
  - In DRAIN, no new reads are issued. In-flight words are still captured and delivered.
- `m_ready` may toggle freely. `m_data` holds stable while `m_valid`=1 and `m_ready`=0.

## Timing
- Reset (async assert) clears all of the following:
  - Tags, pointers, `buf_count`, `rd_count` = 0.
  - State = IDLE, so `busy` = 0.
  - `m_valid` = 0 and `fifo_read_en` = 0 immediately.
  - Buffer contents are don't-care; `m_data` is not checked while `m_valid`=0.
- Reset mid-operation discards in-flight and buffered words. Deassertion is synchronised by the top level.
- Latency:
  - Read sampled at edge k → captured at edge k+`READ_LATENCY` → `m_valid`=1 in the following cycle.
  - With `m_ready` held high, the word pops at edge k+`READ_LATENCY`+1.
- Throughput: one word per cycle sustained when `m_ready`=1 and the FIFO is non-empty, given `SKID_DEPTH` ≥ `READ_LATENCY`+1.
- Backpressure: with `m_ready`=0, at most `SKID_DEPTH` reads are issued. `fifo_read_en` stays 0 until a pop frees a credit. Re-issue is in the same cycle the pop is visible, i.e. combinationally on outstanding.
- FIFO goes empty while reads are in flight: those reads still complete. There is no read while `fifo_empty`=1.

## Test plan
- Reset, then load words 0x1..0x5 into the FIFO, `enable`=1, `m_ready`=1.
  - Required: reads on 5 consecutive edges.
  - Outputs 0x1..0x5 in order, the first popped 5 edges after the first read.
  - `rd_count`=5, then `busy`→0 after `enable`=0.
- 16 words loaded, `m_ready`=0.
  - Required: exactly 8 `fifo_read_en` pulses, then stall.
  - `m_valid`=1 with `m_data`=word0 stable.
- Release `m_ready`=1 from that stall.
  - Required: continuous delivery of words 0..15 without gaps after refill.
  - No overflow assertion fires.
- 6 words loaded, `enable` dropped after 3 reads.
  - Required: exactly 3 words delivered; state passes through DRAIN to IDLE.
  - The FIFO retains 3 words.
- Reset asserted while 3 reads are in flight.
  - Required: `m_valid`=0 and `fifo_read_en`=0 immediately; `rd_count`=0.
  - Nothing is delivered after release until new reads occur.
- Random `m_ready` with 300 words.
  - Required: in-order data, `rd_count` wraps to 44 (300 mod 256).
  - `m_data` stable under stall.

Source files
------------

// File: rtl/fifo_read_agent.sv
// fifo_read_agent: reader-side agent for a fixed-latency FIFO read port.
// Credit-gated reads, in-flight tag tracking, skid buffer, valid/ready output.
// Revision: 1.0
`default_nettype none

module fifo_read_agent #(
  parameter int DATA_WIDTH   = 4,
  parameter int READ_LATENCY = 4,
  parameter int SKID_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [7:0]            rd_count
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int CNT_W = PTR_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic [CNT_W-1:0]        inflight_q, inflight_d;
  logic [CNT_W-1:0]        buf_count_q, buf_count_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [7:0]              rd_count_q, rd_count_d;
  logic [DATA_WIDTH-1:0]   mem [SKID_DEPTH];

  logic             capture;
  logic             pop;
  logic [CNT_W-1:0] outstanding;

  // Every issued read holds a credit until its word leaves the buffer,
  // so a capture can never land in a full buffer without a matching pop.
  assign outstanding  = inflight_q + buf_count_q;
  assign fifo_read_en = enable & ~fifo_empty & (outstanding < CNT_W'(SKID_DEPTH)) & rst_n;
  assign capture      = tag_q[READ_LATENCY-1];
  assign m_valid      = (buf_count_q != '0);
  assign pop          = m_valid & m_ready;
  assign m_data       = mem[rd_ptr_q];
  assign busy         = (state_q != ST_IDLE);
  assign rd_count     = rd_count_q;

  generate
    if (READ_LATENCY == 1) begin : g_tag_single
      assign tag_d = fifo_read_en;
    end else begin : g_tag_shift
      assign tag_d = {tag_q[READ_LATENCY-2:0], fifo_read_en};
    end
  endgenerate

  always_comb begin
    inflight_d  = inflight_q + CNT_W'(fifo_read_en) - CNT_W'(capture);
    buf_count_d = buf_count_q + CNT_W'(capture) - CNT_W'(pop);
    wr_ptr_d    = capture ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    rd_count_d  = pop ? rd_count_q + 8'd1 : rd_count_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_d = (outstanding != '0) ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (enable)                   state_d = ST_RUN;
        else if (outstanding == '0)   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tag_q       <= '0;
      inflight_q  <= '0;
      buf_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      inflight_q  <= inflight_d;
      buf_count_q <= buf_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_count_q  <= rd_count_d;
    end
  end

  // Storage needs no reset; entries are only observed once buf_count covers them.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr_q] <= fifo_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_agent.sv
// tb_fifo_read_agent: FIFO model with fixed read latency plus an in-order
// scoreboard for fifo_read_agent. Revision: 1.0
`default_nettype none

module tb_fifo_read_agent;

  localparam int DW = 4;
  localparam int RL = 4;
  localparam int SD = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_read_en;
  logic [DW-1:0] fifo_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          busy;
  logic [7:0]    rd_count;

  always #5 clk = ~clk;

  fifo_read_agent #(
    .DATA_WIDTH  (DW),
    .READ_LATENCY(RL),
    .SKID_DEPTH  (SD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_read_en(fifo_read_en),
    .fifo_data   (fifo_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .busy        (busy),
    .rd_count    (rd_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pipe [RL];
  int cyc = 0;
  int n_reads, n_pops, first_rd, last_rd, first_pop, last_pop;
  int outst = 0, max_outst, stall_bad, mrc = 0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  bit rd_s, pop_s;
  logic [DW-1:0] w;

  // FIFO model and scoreboard: sample mid-cycle, apply just after the edge.
  always begin
    @(negedge clk);
    rd_s  = fifo_read_en && rst_n;
    pop_s = m_valid && m_ready && rst_n;
    if (rst_n && prev_stall && m_valid && (m_data !== prev_data)) stall_bad++;
    prev_stall = rst_n && m_valid && !m_ready;
    prev_data  = m_data;
    if (pop_s) begin
      if (exp_q.size() == 0) check_eq("pop_has_exp", exp_q.size(), 1);
      else check_eq("data", m_data, exp_q.pop_front());
      check_eq("rd_count_run", rd_count, mrc);
      mrc = (mrc + 1) % 256;
    end
    @(posedge clk);
    #1;
    cyc++;
    w = '0;
    if (rd_s) begin
      if (fifo_q.size() != 0) w = fifo_q.pop_front();
      exp_q.push_back(w);
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      n_reads++;
      outst++;
    end
    if (pop_s) begin
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      n_pops++;
      outst--;
    end
    if (outst > max_outst) max_outst = outst;
    for (int i = RL - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0]    = w;
    fifo_data  = pipe[RL-1];
    fifo_empty = (fifo_q.size() == 0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_stats();
    n_reads = 0; n_pops = 0; first_rd = -1; last_rd = -1;
    first_pop = -1; last_pop = -1; max_outst = outst; stall_bad = 0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
    fifo_q.delete(); exp_q.delete();
    outst = 0; mrc = 0;
    clr_stats();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load(input int n, input int base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) fifo_q.push_back(DW'($urandom));
      else     fifo_q.push_back(DW'(base + i));
    end
    repeat (2) tick();
  endtask

  task automatic wait_pops(input int n, input int budget, input bit rnd_ready);
    for (int i = 0; i < budget && n_pops < n; i++) begin
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check_eq("wait_pops", n_pops, n);
  endtask

  initial begin
    for (int i = 0; i < RL; i++) pipe[i] = '0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
    clr_stats();
    repeat (2) tick();
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_read_en", fifo_read_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd_count", rd_count, 0);
    rst_n = 1'b1;
    tick();

    // Basic five-word transfer
    do_reset();
    load(5, 1, 1'b0);
    clr_stats();
    enable = 1'b1; m_ready = 1'b1;
    wait_pops(5, 60, 1'b0);
    check_eq("t1_reads", n_reads, 5);
    check_eq("t1_consec", last_rd - first_rd, 4);
    check_eq("t1_latency", first_pop - first_rd, 5);
    check_eq("t1_rd_count", rd_count, 5);
    check_eq("t1_busy_run", busy, 1);
    enable = 1'b0;
    repeat (2) tick();
    check_eq("t1_busy_idle", busy, 0);

    // Backpressure stall, then release
    do_reset();
    load(16, 0, 1'b0);
    clr_stats();
    enable = 1'b1; m_ready = 1'b0;
    repeat (25) tick();
    check_eq("t2_reads", n_reads, SD);
    check_eq("t2_m_valid", m_valid, 1);
    check_eq("t2_m_data", m_data, 0);
    check_eq("t2_fifo_left", fifo_q.size(), 8);
    check_eq("t2_stall_stable", stall_bad, 0);
    m_ready = 1'b1;
    wait_pops(16, 100, 1'b0);
    check_eq("t2_no_gaps", last_pop - first_pop, 15);
    check_eq("t2_max_outst", max_outst, SD);
    check_eq("t2_rd_count", rd_count, 16);
    enable = 1'b0;
    repeat (2) tick();

    // Enable dropped after three reads: drain then idle
    do_reset();
    load(6, 5, 1'b0);
    clr_stats();
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20 && n_reads < 3; i++) tick();
    enable = 1'b0;
    repeat (2) tick();
    check_eq("t3_busy_drain", busy, 1);
    for (int i = 0; i < 30 && busy; i++) tick();
    check_eq("t3_busy_idle", busy, 0);
    check_eq("t3_pops", n_pops, 3);
    check_eq("t3_reads", n_reads, 3);
    check_eq("t3_fifo_left", fifo_q.size(), 3);
    check_eq("t3_rd_count", rd_count, 3);
    fifo_q.delete();
    repeat (2) tick();

    // Reset with reads in flight (rd_count is nonzero beforehand)
    load(8, 8, 1'b0);
    clr_stats();
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20 && n_reads < 3; i++) tick();
    rst_n = 1'b0; enable = 1'b0;
    exp_q.delete(); outst = 0; mrc = 0;
    #1;
    check_eq("t4_m_valid", m_valid, 0);
    check_eq("t4_read_en", fifo_read_en, 0);
    check_eq("t4_rd_count", rd_count, 0);
    check_eq("t4_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    clr_stats();
    repeat (10) tick();
    check_eq("t4_no_deliver", n_pops, 0);
    check_eq("t4_m_valid_post", m_valid, 0);
    check_eq("t4_fifo_left", fifo_q.size(), 5);
    enable = 1'b1;
    wait_pops(5, 60, 1'b0);
    check_eq("t4_rd_count_new", rd_count, 5);
    enable = 1'b0;
    repeat (3) tick();

    // Random backpressure over 300 words
    do_reset();
    load(300, 0, 1'b1);
    clr_stats();
    enable = 1'b1;
    wait_pops(300, 4000, 1'b1);
    check_eq("t5_rd_count_wrap", rd_count, 44);
    check_eq("t5_exp_empty", exp_q.size(), 0);
    check_eq("t5_stall_stable", stall_bad, 0);
    check_eq("t5_outst_bound", (max_outst <= SD), 1);
    enable = 1'b0;
    m_ready = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
